// File: rtl/closure_monitor.sv
// Phase-closure monitor: signed sum of NCH phasemeter channels, averaged over 2^DEC_LOG2 closures.
// Optional macro CLOSURE_ALARM_EN builds the |mean| threshold alarm; otherwise alarm is tied low.
module closure_monitor #(
  parameter int unsigned     NCH       = 3,
  parameter int unsigned     PW        = 32,
  parameter int unsigned     DEC_LOG2  = 2,
  parameter logic [NCH-1:0]  SIGN_MASK = NCH'(3'b010),
  parameter int unsigned     THRESH    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*PW-1:0] s_phase,
  input  logic [NCH-1:0]    s_valid,
  output logic [PW-1:0]     m_closure,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              drop,
  output logic              overrun,
  output logic              alarm
);

  localparam int unsigned AW = PW + DEC_LOG2;
  localparam int unsigned CW = DEC_LOG2 + 1;
  localparam int unsigned IW = $clog2(NCH + 1);

  typedef enum logic [1:0] {COLLECT, SUM, ACC, EMIT} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       ch_reg [NCH];
  logic [PW-1:0]       snap   [NCH];
  logic [NCH-1:0]      pending;
  logic [PW-1:0]       sum;
  logic signed [AW-1:0] acc;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                snap_en, add_en, acc_en, emit_en;
  logic [PW-1:0]       snap_sel;
  logic                sub_sel;
  logic [PW-1:0]       mean;

  assign mean = PW'(acc >>> DEC_LOG2);

  always_comb begin
    snap_sel = '0;
    sub_sel  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == IW'(i)) begin
        snap_sel = snap[i];
        sub_sel  = SIGN_MASK[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    snap_en   = 1'b0;
    add_en    = 1'b0;
    acc_en    = 1'b0;
    emit_en   = 1'b0;
    case (state)
      COLLECT: if (&pending) begin
        snap_en   = 1'b1;
        state_nxt = SUM;
      end
      // One channel per edge, then one settling edge before ACC.
      SUM: if (idx == IW'(NCH)) state_nxt = ACC;
           else add_en = 1'b1;
      ACC: begin
        acc_en    = 1'b1;
        state_nxt = (cnt == CW'((1 << DEC_LOG2) - 1)) ? EMIT : COLLECT;
      end
      EMIT: begin
        emit_en   = 1'b1;
        state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      pending   <= '0;
      sum       <= '0;
      acc       <= '0;
      cnt       <= '0;
      idx       <= '0;
      m_closure <= '0;
      m_valid   <= 1'b0;
      drop      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ch_reg[i] <= '0;
        snap[i]   <= '0;
      end
    end else begin
      state <= state_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (s_valid[i]) begin
          ch_reg[i] <= s_phase[i*PW +: PW];
          if (pending[i]) drop <= 1'b1;
        end
        // A strobe on the snapshot edge feeds the snapshot directly.
        if (snap_en) begin
          snap[i]    <= s_valid[i] ? s_phase[i*PW +: PW] : ch_reg[i];
          pending[i] <= 1'b0;
        end else if (s_valid[i]) begin
          pending[i] <= 1'b1;
        end
      end
      if (snap_en) begin
        sum <= '0;
        idx <= '0;
      end
      if (add_en) begin
        sum <= sub_sel ? sum - snap_sel : sum + snap_sel;
        idx <= idx + 1'b1;
      end
      if (acc_en) begin
        acc <= acc + AW'($signed(sum));
        cnt <= cnt + 1'b1;
      end
      if (emit_en) begin
        m_closure <= mean;
        m_valid   <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        if (m_valid && !m_ready) overrun <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef CLOSURE_ALARM_EN
  logic [PW:0] mag;
  logic        over, over_prev;

  assign mag  = mean[PW-1] ? (PW+1)'(0) - {1'b1, mean} : {1'b0, mean};
  assign over = mag > (PW+1)'(THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm     <= 1'b0;
      over_prev <= 1'b0;
    end else if (emit_en) begin
      over_prev <= over;
      if (over && over_prev)                  alarm <= 1'b1;
      else if (mag <= (PW+1)'(THRESH / 2))    alarm <= 1'b0;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule
